// File: rtl/synth_env_pkg.sv
`default_nettype none
// ============================================================================
// Module  : synth_env_pkg
// Purpose : Shared types and constants for the AM voice envelope controller.
//           Envelope state encoding, amplitude and frequency widths, amplitude
//           ceiling.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package synth_env_pkg;

  localparam int          AMP_W   = 8;
  localparam int          FREQ_W  = 16;
  localparam logic [7:0]  AMP_MAX = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_t;

endpackage : synth_env_pkg
`default_nettype wire

// File: rtl/audio_tick_gen.sv
`default_nettype none
// ============================================================================
// Module  : audio_tick_gen
// Purpose : Free-running divider 0..CLK_DIV-1 producing a one-cycle tick
//           while the counter sits at its terminal value.
// Ports   : clk_i  - system clock
//           rstn_i - asynchronous active-low reset
//           tick_o - high for one cycle every CLK_DIV cycles
// Rev     : 1.0  initial release
// ============================================================================
module audio_tick_gen #(
  parameter int CLK_DIV = 256
) (
  input  logic clk_i,
  input  logic rstn_i,
  output logic tick_o
);

  localparam int            c_CW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(CLK_DIV - 1);
  localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

  logic [c_CW-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt <= '0;
    end else if (r_cnt == c_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_ONE;
    end
  end

  // Decoded straight from the counter register, so it is glitch-free and
  // aligned with the edge on which the counter wraps.
  assign tick_o = (r_cnt == c_LAST);

endmodule : audio_tick_gen
`default_nettype wire

// File: rtl/am_envelope_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : am_envelope_ctrl
// Purpose : Note-level controller for the AM voice. Accepts note-on/note-off
//           commands over a valid/ready handshake, drives the carrier phase
//           increment and sequences an 8-bit ADSR amplitude envelope.
// Ports   : clk_i, rstn_i               clock, async active-low reset
//           note_valid_i/note_ready_o   command handshake
//           note_on_i                   1 = note-on, 0 = note-off
//           note_freq_i [15:0]          carrier increment for note-on
//           sustain_lvl_i [7:0]         sustain level, captured at note-on
//           freq_o [15:0]               to carrier
//           amplitude_o [7:0]           to AM multiplier
//           busy_o                      state != IDLE
//           state_o [2:0]               envelope state (debug)
// Rev     : 1.0  initial release
// ============================================================================
module am_envelope_ctrl
  import synth_env_pkg::*;
#(
  parameter int CLK_DIV      = 256,
  parameter int ATTACK_STEP  = 4,
  parameter int DECAY_STEP   = 1,
  parameter int RELEASE_STEP = 2
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              note_valid_i,
  output logic              note_ready_o,
  input  logic              note_on_i,
  input  logic [FREQ_W-1:0] note_freq_i,
  input  logic [AMP_W-1:0]  sustain_lvl_i,
  output logic [FREQ_W-1:0] freq_o,
  output logic [AMP_W-1:0]  amplitude_o,
  output logic              busy_o,
  output logic [2:0]        state_o
);

  localparam logic [8:0] c_ATTACK_STEP  = 9'(ATTACK_STEP);
  localparam logic [8:0] c_DECAY_STEP   = 9'(DECAY_STEP);
  localparam logic [8:0] c_RELEASE_STEP = 9'(RELEASE_STEP);
  localparam logic [8:0] c_AMP_MAX9     = {1'b0, AMP_MAX};

  env_state_t        r_state;
  logic [AMP_W-1:0]  r_amp;
  logic [AMP_W-1:0]  r_sus;
  logic [FREQ_W-1:0] r_freq;
  logic              r_ready;

  logic              w_tick;
  logic              w_accept;
  logic [8:0]        w_amp9;
  logic [8:0]        w_attack_sum;
  logic [8:0]        w_decay_floor;

  audio_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .tick_o (w_tick)
  );

  assign w_accept      = note_valid_i && r_ready;
  assign w_amp9        = {1'b0, r_amp};
  assign w_attack_sum  = w_amp9 + c_ATTACK_STEP;
  // Decay/release saturate by comparing against floor+step rather than
  // subtracting first, so the 9-bit path can never underflow.
  assign w_decay_floor = {1'b0, r_sus} + c_DECAY_STEP;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= ST_IDLE;
      r_amp   <= '0;
      r_sus   <= '0;
      r_freq  <= '0;
      r_ready <= 1'b1;
    end else if (w_accept) begin
      // A command owns this edge; any coincident tick step is dropped.
      r_ready <= 1'b0;
      if (note_on_i) begin
        r_freq  <= note_freq_i;
        r_sus   <= sustain_lvl_i;
        r_state <= ST_ATTACK;   // legato: amplitude is kept
      end else if (r_state == ST_ATTACK || r_state == ST_DECAY ||
                   r_state == ST_SUSTAIN) begin
        r_state <= ST_RELEASE;
      end
    end else begin
      r_ready <= 1'b1;
      if (w_tick) begin
        case (r_state)
          ST_ATTACK: begin
            if (w_attack_sum >= c_AMP_MAX9) begin
              r_amp   <= AMP_MAX;
              r_state <= ST_DECAY;
            end else begin
              r_amp   <= w_attack_sum[7:0];
            end
          end
          ST_DECAY: begin
            if (w_amp9 <= w_decay_floor) begin
              r_amp   <= r_sus;
              r_state <= ST_SUSTAIN;
            end else begin
              r_amp   <= 8'(w_amp9 - c_DECAY_STEP);
            end
          end
          ST_RELEASE: begin
            if (w_amp9 <= c_RELEASE_STEP) begin
              r_amp   <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_amp   <= 8'(w_amp9 - c_RELEASE_STEP);
            end
          end
          default: begin
            // IDLE and SUSTAIN hold until a command arrives.
          end
        endcase
      end
    end
  end

  assign note_ready_o = r_ready;
  assign freq_o       = r_freq;
  assign amplitude_o  = r_amp;
  assign busy_o       = (r_state != ST_IDLE);
  assign state_o      = r_state;

endmodule : am_envelope_ctrl
`default_nettype wire

// File: tb/tb_am_envelope_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_am_envelope_ctrl
// Purpose : Directed, table-driven bench for am_envelope_ctrl with
//           CLK_DIV=4, ATTACK_STEP=64, DECAY_STEP=16, RELEASE_STEP=32.
// Rev     : 1.0  initial release
// ============================================================================
module tb_am_envelope_ctrl;

  localparam int DIV = 4;

  logic        clk;
  logic        rstn;
  logic        note_valid;
  logic        note_ready;
  logic        note_on;
  logic [15:0] note_freq;
  logic [7:0]  sustain_lvl;
  logic [15:0] freq;
  logic [7:0]  amplitude;
  logic        busy;
  logic [2:0]  state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;   // posedges since reset release

  am_envelope_ctrl #(
    .CLK_DIV      (4),
    .ATTACK_STEP  (64),
    .DECAY_STEP   (16),
    .RELEASE_STEP (32)
  ) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .note_valid_i  (note_valid),
    .note_ready_o  (note_ready),
    .note_on_i     (note_on),
    .note_freq_i   (note_freq),
    .sustain_lvl_i (sustain_lvl),
    .freq_o        (freq),
    .amplitude_o   (amplitude),
    .busy_o        (busy),
    .state_o       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Advance to the negedge following the next tick edge.
  task automatic next_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((cyc % DIV) != 0 && n < 3 * DIV);
    if ((cyc % DIV) != 0) chk("tick_align", 32'(cyc % DIV), 32'd0);
  endtask

  // Issue one command whose accept edge is not a tick edge.
  task automatic send(input logic on, input logic [15:0] f, input logic [7:0] s);
    int n = 0;
    while ((cyc % DIV) != 0 && n < 3 * DIV) begin
      @(negedge clk);
      n++;
    end
    note_valid  = 1'b1;
    note_on     = on;
    note_freq   = f;
    sustain_lvl = s;
    @(negedge clk);
    note_valid  = 1'b0;
    note_freq   = 16'hDEAD;
    sustain_lvl = 8'h5A;
  endtask

  typedef struct {
    int          op;      // 0 tick, 1 note-on, 2 note-off
    logic [15:0] f;
    logic [7:0]  s;
    logic [7:0]  amp;
    logic [2:0]  st;
    logic [15:0] fq;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int op, input logic [15:0] f, input logic [7:0] s,
                     input logic [7:0] amp, input logic [2:0] st, input logic [15:0] fq);
    vec_t v;
    v.op = op; v.f = f; v.s = s; v.amp = amp; v.st = st; v.fq = fq;
    vecs.push_back(v);
  endtask

  initial begin
    rstn        = 1'b0;
    note_valid  = 1'b0;
    note_on     = 1'b0;
    note_freq   = '0;
    sustain_lvl = '0;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    chk("rst_amp",   32'(amplitude),  32'd0);
    chk("rst_freq",  32'(freq),       32'd0);
    chk("rst_state", 32'(state),      32'd0);
    chk("rst_ready", 32'(note_ready), 32'd1);
    chk("rst_busy",  32'(busy),       32'd0);
    rstn = 1'b1;

    // ---- full ADSR, release, legato retrigger ----
    add(1, 16'h0400, 8'h80, 8'd0,   3'd1, 16'h0400);
    add(0, 0, 0, 8'd64,  3'd1, 16'h0400);
    add(0, 0, 0, 8'd128, 3'd1, 16'h0400);
    add(0, 0, 0, 8'd192, 3'd1, 16'h0400);
    add(0, 0, 0, 8'd255, 3'd2, 16'h0400);
    add(0, 0, 0, 8'd239, 3'd2, 16'h0400);
    add(0, 0, 0, 8'd223, 3'd2, 16'h0400);
    add(0, 0, 0, 8'd207, 3'd2, 16'h0400);
    add(0, 0, 0, 8'd191, 3'd2, 16'h0400);
    add(0, 0, 0, 8'd175, 3'd2, 16'h0400);
    add(0, 0, 0, 8'd159, 3'd2, 16'h0400);
    add(0, 0, 0, 8'd143, 3'd2, 16'h0400);
    add(0, 0, 0, 8'd128, 3'd3, 16'h0400);
    add(0, 0, 0, 8'd128, 3'd3, 16'h0400);
    add(0, 0, 0, 8'd128, 3'd3, 16'h0400);
    add(2, 0, 0, 8'd128, 3'd4, 16'h0400);
    add(0, 0, 0, 8'd96,  3'd4, 16'h0400);
    add(0, 0, 0, 8'd64,  3'd4, 16'h0400);
    add(0, 0, 0, 8'd32,  3'd4, 16'h0400);
    add(0, 0, 0, 8'd0,   3'd0, 16'h0400);
    add(0, 0, 0, 8'd0,   3'd0, 16'h0400);
    add(1, 16'h0500, 8'hC0, 8'd0, 3'd1, 16'h0500);
    add(0, 0, 0, 8'd64,  3'd1, 16'h0500);
    add(0, 0, 0, 8'd128, 3'd1, 16'h0500);
    add(0, 0, 0, 8'd192, 3'd1, 16'h0500);
    add(0, 0, 0, 8'd255, 3'd2, 16'h0500);
    add(0, 0, 0, 8'd239, 3'd2, 16'h0500);
    add(0, 0, 0, 8'd223, 3'd2, 16'h0500);
    add(0, 0, 0, 8'd207, 3'd2, 16'h0500);
    add(0, 0, 0, 8'd192, 3'd3, 16'h0500);
    add(2, 0, 0, 8'd192, 3'd4, 16'h0500);
    add(0, 0, 0, 8'd160, 3'd4, 16'h0500);
    add(0, 0, 0, 8'd128, 3'd4, 16'h0500);
    add(0, 0, 0, 8'd96,  3'd4, 16'h0500);
    add(0, 0, 0, 8'd64,  3'd4, 16'h0500);
    add(1, 16'h0600, 8'h40, 8'd64, 3'd1, 16'h0600);
    add(0, 0, 0, 8'd128, 3'd1, 16'h0600);
    add(2, 0, 0, 8'd128, 3'd4, 16'h0600);
    add(0, 0, 0, 8'd96,  3'd4, 16'h0600);
    add(0, 0, 0, 8'd64,  3'd4, 16'h0600);
    add(0, 0, 0, 8'd32,  3'd4, 16'h0600);
    add(0, 0, 0, 8'd0,   3'd0, 16'h0600);

    foreach (vecs[i]) begin
      case (vecs[i].op)
        0:       next_tick();
        1:       send(1'b1, vecs[i].f, vecs[i].s);
        default: send(1'b0, 16'h0, 8'h0);
      endcase
      chk($sformatf("v%0d_amp", i),   32'(amplitude), 32'(vecs[i].amp));
      chk($sformatf("v%0d_state", i), 32'(state),     32'(vecs[i].st));
      chk($sformatf("v%0d_freq", i),  32'(freq),      32'(vecs[i].fq));
      chk($sformatf("v%0d_busy", i),  32'(busy),      32'(vecs[i].st != 3'd0));
      if (vecs[i].op != 0)
        chk($sformatf("v%0d_ready", i), 32'(note_ready), 32'd0);
    end

    // ---- command on the same edge as a tick ----
    send(1'b1, 16'h0100, 8'h80);
    next_tick();
    chk("col_pre_amp", 32'(amplitude), 32'd64);
    begin
      int n = 0;
      while ((cyc % DIV) != DIV - 1 && n < 3 * DIV) begin
        @(negedge clk);
        n++;
      end
    end
    note_valid = 1'b1; note_on = 1'b1; note_freq = 16'h0200; sustain_lvl = 8'h80;
    @(negedge clk);
    note_valid = 1'b0;
    chk("col_amp",   32'(amplitude),  32'd64);
    chk("col_state", 32'(state),      32'd1);
    chk("col_freq",  32'(freq),       32'h0200);
    chk("col_ready0", 32'(note_ready), 32'd0);
    @(negedge clk);
    chk("col_ready1", 32'(note_ready), 32'd1);
    repeat (2) @(negedge clk);
    chk("col_hold_amp", 32'(amplitude), 32'd64);
    @(negedge clk);
    chk("col_next_amp", 32'(amplitude), 32'd128);

    // ---- note-off in IDLE ----
    send(1'b0, 16'h0, 8'h0);
    chk("rel_state", 32'(state), 32'd4);
    for (int k = 0; k < 8 && state != 3'd0; k++) next_tick();
    chk("rel_idle_state", 32'(state),     32'd0);
    chk("rel_idle_amp",   32'(amplitude), 32'd0);
    send(1'b0, 16'h0, 8'h0);
    chk("idle_off_state", 32'(state),      32'd0);
    chk("idle_off_busy",  32'(busy),       32'd0);
    chk("idle_off_freq",  32'(freq),       32'h0200);
    chk("idle_off_ready", 32'(note_ready), 32'd0);
    @(negedge clk);
    chk("idle_off_ready1", 32'(note_ready), 32'd1);

    // ---- asynchronous reset mid-ATTACK ----
    send(1'b1, 16'h0300, 8'h00);
    next_tick();
    chk("ar_pre_amp", 32'(amplitude), 32'd64);
    #2 rstn = 1'b0;
    #1;
    chk("ar_amp",   32'(amplitude),  32'd0);
    chk("ar_state", 32'(state),      32'd0);
    chk("ar_freq",  32'(freq),       32'd0);
    chk("ar_ready", 32'(note_ready), 32'd1);
    chk("ar_busy",  32'(busy),       32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (6) @(negedge clk);
    chk("ar_after_state", 32'(state),     32'd0);
    chk("ar_after_amp",   32'(amplitude), 32'd0);

    // ---- sustain level 0 ----
    send(1'b1, 16'h0700, 8'h00);
    for (int k = 0; k < 24 && state != 3'd3; k++) next_tick();
    chk("s0_state", 32'(state),     32'd3);
    chk("s0_amp",   32'(amplitude), 32'd0);
    chk("s0_busy",  32'(busy),      32'd1);
    next_tick();
    next_tick();
    chk("s0_hold_state", 32'(state),     32'd3);
    chk("s0_hold_amp",   32'(amplitude), 32'd0);
    send(1'b0, 16'h0, 8'h0);
    chk("s0_rel_state", 32'(state), 32'd4);
    next_tick();
    chk("s0_idle_state", 32'(state), 32'd0);
    chk("s0_idle_freq",  32'(freq),  32'h0700);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_am_envelope_ctrl
`default_nettype wire
